// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 8-bit pipelined CPU.
//
// Drives the byte-wide memory read address from the PC and assembles 1- or
// 2-byte instructions into the IF/ID register. An opcode whose upper nibble
// equals LONG_OP carries one immediate byte, fetched on the following cycle.
//
// Ports:
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   stall       decode cannot accept; all fetch state freezes
//   flush       redirect from execute; wins over stall and mem_busy
//   flush_pc    redirect target, sampled while flush=1
//   mem_busy    data stage owns the memory port; mem_rdata is not consumed
//   mem_addr    read address (combinational copy of the PC register)
//   mem_rdata   same-cycle read data for mem_addr
//   if_valid    IF/ID holds a real instruction
//   if_instr    opcode byte
//   if_imm      immediate byte, 8'h00 for 1-byte instructions
//   if_pc       address of the opcode byte
//   if_pc_next  address following the whole instruction
module fetch_stage #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        LONG_OP  = 4'hC
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              mem_busy,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              if_valid,
  output logic [7:0]        if_instr,
  output logic [7:0]        if_imm,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_next
);

  typedef enum logic {S_OP, S_IMM} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        op_hold_q, op_hold_d;
  logic [ADDR_W-1:0] op_pc_q, op_pc_d;
  logic              vld_d;
  logic [7:0]        instr_d, imm_d;
  logic [ADDR_W-1:0] ipc_d, ipc_next_d;
  logic [ADDR_W-1:0] pc_inc;

  // PC arithmetic wraps naturally at the address width.
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign mem_addr = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_hold_d  = op_hold_q;
    op_pc_d    = op_pc_q;
    vld_d      = if_valid;
    instr_d    = if_instr;
    imm_d      = if_imm;
    ipc_d      = if_pc;
    ipc_next_d = if_pc_next;

    if (flush) begin
      // Redirect drops any half-assembled 2-byte instruction.
      pc_d    = flush_pc;
      state_d = S_OP;
      vld_d   = 1'b0;
    end else if (stall) begin
      // Hold everything.
    end else if (mem_busy) begin
      // Port is taken: insert a bubble without advancing.
      vld_d = 1'b0;
    end else begin
      case (state_q)
        S_OP: begin
          pc_d = pc_inc;
          if (mem_rdata[7:4] != LONG_OP) begin
            vld_d      = 1'b1;
            instr_d    = mem_rdata;
            imm_d      = 8'h00;
            ipc_d      = pc_q;
            ipc_next_d = pc_inc;
          end else begin
            op_hold_d = mem_rdata;
            op_pc_d   = pc_q;
            vld_d     = 1'b0;
            state_d   = S_IMM;
          end
        end
        S_IMM: begin
          vld_d      = 1'b1;
          instr_d    = op_hold_q;
          imm_d      = mem_rdata;
          ipc_d      = op_pc_q;
          ipc_next_d = pc_inc;
          pc_d       = pc_inc;
          state_d    = S_OP;
        end
        default: state_d = S_OP;
      endcase
    end
  end

  // IF/ID register boundary
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_OP;
      pc_q       <= RESET_PC;
      op_hold_q  <= 8'h00;
      op_pc_q    <= '0;
      if_valid   <= 1'b0;
      if_instr   <= 8'h00;
      if_imm     <= 8'h00;
      if_pc      <= '0;
      if_pc_next <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      op_hold_q  <= op_hold_d;
      op_pc_q    <= op_pc_d;
      if_valid   <= vld_d;
      if_instr   <= instr_d;
      if_imm     <= imm_d;
      if_pc      <= ipc_d;
      if_pc_next <= ipc_next_d;
    end
  end

endmodule
